ethernet_driver: RTL and testbench

//  RMII receive front end for a LAN8720-class PHY, clocked by the 50 MHz RMII reference clock.
//  - Runs the PHY hardware-reset / mode-strap sequence.
//  - Strips the preamble and SFD from each received frame.
//  - Streams payload dibits (FCS included) one per cycle to a downstream dibits_to_bytes packer.
//  - Signals end of frame with a one-cycle done pulse.

---
 rtl/ethernet_driver.sv | 200 ++++++++++++++++++++
 tb/tb_ethernet_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_driver.sv
// RMII receive front end: PHY reset/strap sequencing, preamble/SFD stripping, dibit streaming.
// Optional rxerr tracking with an err output when ETHERNET_DRIVER_RXERR_EN is defined.
module ethernet_driver #(
  parameter int unsigned RESET_CYCLES = 10,
  parameter int unsigned STRAP_HOLD   = 2,
  parameter logic [1:0]  STRAP_RXD    = 2'b11,
  parameter logic        STRAP_CRSDV  = 1'b1,
  parameter logic        STRAP_RXERR  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        crsdv,
  inout  wire        rxerr,
  inout  wire  [1:0] rxd,
  output logic       intn,
  output logic       rstn,
  output logic [1:0] out,
  output logic       outclk,
  output logic       done
`ifdef ETHERNET_DRIVER_RXERR_EN
  ,
  output logic       err
`endif
);

  localparam int unsigned SEQ_LEN = RESET_CYCLES + STRAP_HOLD;
  localparam int unsigned CNT_W   = $clog2(SEQ_LEN + 1);

  typedef enum logic [2:0] {
    PHY_RST,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rstn_q, rstn_d;
  logic             strap_q, strap_d;
  logic             intn_q, intn_d;
  logic             crsdv_q, crsdv_d;
  logic [1:0]       rxd_q, rxd_d;
  logic [1:0]       out_q, out_d;
  logic             outclk_q, outclk_d;
  logic             done_q, done_d;

  // Straps are driven only while strap_q is set, otherwise the pins are inputs.
  assign crsdv = strap_q ? STRAP_CRSDV : 1'bz;
  assign rxerr = strap_q ? STRAP_RXERR : 1'bz;
  assign rxd   = strap_q ? STRAP_RXD   : 2'bzz;

  assign intn   = intn_q;
  assign rstn   = rstn_q;
  assign out    = out_q;
  assign outclk = outclk_q;
  assign done   = done_q;

`ifdef ETHERNET_DRIVER_RXERR_EN
  logic rxerr_q, rxerr_d;
  logic flag_q, flag_d;
  logic err_q, err_d;

  assign err = err_q;
`else
  logic rxerr_unused;

  assign rxerr_unused = rxerr;
`endif

  // Input sampling stage; our own strap values are masked so they never look like traffic.
  always_comb begin
    crsdv_d = strap_q ? 1'b0 : crsdv;
    rxd_d   = strap_q ? 2'b00 : rxd;
`ifdef ETHERNET_DRIVER_RXERR_EN
    rxerr_d = strap_q ? 1'b0 : rxerr;
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rstn_d   = rstn_q;
    strap_d  = strap_q;
    intn_d   = 1'b1;
    out_d    = out_q;
    outclk_d = 1'b0;
    done_d   = 1'b0;
    cnt_inc  = cnt_q + CNT_W'(1);
`ifdef ETHERNET_DRIVER_RXERR_EN
    flag_d   = flag_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      PHY_RST: begin
        cnt_d = cnt_inc;
        if (32'(cnt_inc) >= RESET_CYCLES) begin
          rstn_d = 1'b1;
        end
        if (32'(cnt_inc) >= SEQ_LEN) begin
          strap_d = 1'b0;
          state_d = IDLE;
        end
      end

      IDLE: begin
`ifdef ETHERNET_DRIVER_RXERR_EN
        flag_d = 1'b0;
`endif
        if (crsdv_q) begin
          state_d = PREAMBLE;
        end
      end

      PREAMBLE: begin
        if (!crsdv_q) begin
          state_d = IDLE;
        end else begin
          case (rxd_q)
            2'b11:   state_d = DATA;
            2'b10:   state_d = DROP;
            default: state_d = PREAMBLE;
          endcase
        end
      end

      DATA: begin
        if (crsdv_q) begin
          out_d    = rxd_q;
          outclk_d = 1'b1;
`ifdef ETHERNET_DRIVER_RXERR_EN
          if (rxerr_q) begin
            flag_d = 1'b1;
          end
`endif
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef ETHERNET_DRIVER_RXERR_EN
          err_d   = flag_q;
          flag_d  = 1'b0;
`endif
        end
      end

      DROP: begin
        if (!crsdv_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = PHY_RST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PHY_RST;
      cnt_q    <= '0;
      rstn_q   <= 1'b0;
      strap_q  <= 1'b1;
      intn_q   <= 1'b1;
      crsdv_q  <= 1'b0;
      rxd_q    <= 2'b00;
      out_q    <= 2'b00;
      outclk_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rstn_q   <= rstn_d;
      strap_q  <= strap_d;
      intn_q   <= intn_d;
      crsdv_q  <= crsdv_d;
      rxd_q    <= rxd_d;
      out_q    <= out_d;
      outclk_q <= outclk_d;
      done_q   <= done_d;
    end
  end

`ifdef ETHERNET_DRIVER_RXERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxerr_q <= 1'b0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rxerr_q <= rxerr_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ethernet_driver.sv
// Randomized bench for ethernet_driver: strap sequence, frame parsing against a frame-level model,
// back-to-back frames and reset during a frame.
`timescale 1ns/1ps
module tb_ethernet_driver;

  logic       clk = 1'b0;
  logic       reset;
  wire        crsdv;
  wire        rxerr;
  wire  [1:0] rxd;
  logic       intn;
  logic       rstn;
  logic [1:0] out;
  logic       outclk;
  logic       done;
`ifdef ETHERNET_DRIVER_RXERR_EN
  logic       err;
`endif

  logic       tb_drv;
  logic       tb_crsdv;
  logic       tb_rxerr;
  logic [1:0] tb_rxd;

  assign crsdv = tb_drv ? tb_crsdv : 1'bz;
  assign rxerr = tb_drv ? tb_rxerr : 1'bz;
  assign rxd   = tb_drv ? tb_rxd   : 2'bzz;

  ethernet_driver dut (
    .clk    (clk),
    .reset  (reset),
    .crsdv  (crsdv),
    .rxerr  (rxerr),
    .rxd    (rxd),
    .intn   (intn),
    .rstn   (rstn),
    .out    (out),
    .outclk (outclk),
    .done   (done)
`ifdef ETHERNET_DRIVER_RXERR_EN
    ,
    .err    (err)
`endif
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pin stream: one entry per clock cycle.
  bit       q_dv[$];
  bit [1:0] q_d[$];
  bit       q_er[$];

  task automatic push(input bit dv, input bit [1:0] d, input bit er);
    q_dv.push_back(dv);
    q_d.push_back(d);
    q_er.push_back(er);
  endtask

  task automatic push_n(input int n, input bit dv, input bit [1:0] d);
    for (int i = 0; i < n; i++) push(dv, d, 1'b0);
  endtask

  task automatic drive_pin(input bit dv, input bit [1:0] d, input bit er);
    tb_crsdv = dv;
    tb_rxd   = d;
    tb_rxerr = er;
  endtask

  // Expected output per cycle of the stream, derived frame by frame.
  bit       ex_clk[];
  bit [1:0] ex_dat[];
  bit       ex_done[];
  bit       ex_err[];

  task automatic build_model();
    int n;
    int p;
    int s;
    int e;
    int sfd;
    bit bad;
    n = q_dv.size();
    ex_clk  = new[n + 4];
    ex_dat  = new[n + 4];
    ex_done = new[n + 4];
    ex_err  = new[n + 4];
    p = 0;
    while (p < n) begin
      if (!q_dv[p]) begin
        p++;
      end else begin
        s = p;
        while (p < n && q_dv[p]) p++;
        e = p - 1;
        // First dibit of a carrier run only wakes the receiver; then look for SFD or a bad nibble.
        sfd = -1;
        for (int i = s + 1; i <= e; i++) begin
          if (q_d[i] == 2'b10) break;
          if (q_d[i] == 2'b11) begin
            sfd = i;
            break;
          end
        end
        if (sfd >= 0) begin
          bad = 1'b0;
          for (int i = sfd + 1; i <= e; i++) begin
            ex_clk[i + 2] = 1'b1;
            ex_dat[i + 2] = q_d[i];
            bad |= q_er[i];
          end
          ex_done[e + 3] = 1'b1;
          ex_err[e + 3]  = bad;
        end
      end
    end
  endtask

  task automatic build_stream();
    int pre;
    int kind;
    int len;
    push_n(4, 1'b0, 2'b00);
    // Long preamble then 0xAA 0xAA payload.
    push_n(5, 1'b1, 2'b00);
    push_n(27, 1'b1, 2'b01);
    push(1'b1, 2'b11, 1'b0);
    push_n(8, 1'b1, 2'b10);
    push_n(1, 1'b0, 2'b00);
    // Preamble aborted by a 10 dibit.
    push_n(10, 1'b1, 2'b01);
    push_n(4, 1'b1, 2'b10);
    push_n(2, 1'b0, 2'b00);
    // Two 0x55 frames with a single idle cycle between them.
    for (int f = 0; f < 2; f++) begin
      push(1'b1, 2'b01, 1'b0);
      push(1'b1, 2'b11, 1'b0);
      push_n(4, 1'b1, 2'b01);
      push_n(1, 1'b0, 2'b00);
    end
    // Frame with one rxerr cycle mid-payload, then a clean frame.
    for (int f = 0; f < 2; f++) begin
      push_n(2, 1'b1, 2'b01);
      push(1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 8; i++) push(1'b1, 2'(i), (f == 0) && (i == 3));
      push_n(2, 1'b0, 2'b00);
    end
    // Random frames.
    for (int f = 0; f < 60; f++) begin
      pre = $urandom_range(1, 8);
      for (int i = 0; i < pre; i++) push(1'b1, 2'($urandom_range(0, 1)), 1'b0);
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        push(1'b1, 2'b11, 1'b0);
        len = $urandom_range(0, 16);
        for (int i = 0; i < len; i++) push(1'b1, 2'($urandom), ($urandom_range(0, 15) == 0));
      end else if (kind == 2) begin
        push(1'b1, 2'b10, 1'b0);
        len = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) push(1'b1, 2'($urandom), 1'b0);
      end
      push_n($urandom_range(1, 3), 1'b0, 2'b00);
    end
    push_n(6, 1'b0, 2'b00);
  endtask

  initial begin
    bit [1:0] last_out;
    int n;

    tb_drv = 1'b0;
    drive_pin(1'b0, 2'b00, 1'b0);
    reset = 1'b1;

    // Reset held for five cycles.
    repeat (5) @(negedge clk);
    check("rst_rstn", rstn, 1'b0);
    check("rst_intn", intn, 1'b1);
    check("rst_out", out, 2'b00);
    check("rst_outclk", outclk, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strap_rxd", rxd, 2'b11);
    check("rst_strap_crsdv", crsdv, 1'b1);
    check("rst_strap_rxerr", rxerr, 1'b0);
`ifdef ETHERNET_DRIVER_RXERR_EN
    check("rst_err", err, 1'b0);
`endif
    reset = 1'b0;

    // Strap sequence after release.
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      check("seq_rstn", rstn, (j >= 10) ? 1 : 0);
      check("seq_intn", intn, 1'b1);
      if (j <= 11) begin
        check("seq_strap_rxd", rxd, 2'b11);
        check("seq_strap_crsdv", crsdv, 1'b1);
        check("seq_strap_rxerr", rxerr, 1'b0);
      end else if (j <= 13) begin
        check("seq_rxd_released", rxd !== 2'b11, 1'b1);
        check("seq_crsdv_released", crsdv !== 1'b1, 1'b1);
      end
    end
    tb_drv = 1'b1;
    drive_pin(1'b0, 2'b00, 1'b0);

    build_stream();
    build_model();
    n = q_dv.size();
    last_out = 2'b00;
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (ex_clk[k]) last_out = ex_dat[k];
      check("strm_outclk", outclk, ex_clk[k]);
      check("strm_done", done, ex_done[k]);
      check("strm_out", out, last_out);
`ifdef ETHERNET_DRIVER_RXERR_EN
      check("strm_err", err, ex_err[k]);
`endif
      if (k < n) drive_pin(q_dv[k], q_d[k], q_er[k]);
      else       drive_pin(1'b0, 2'b00, 1'b0);
    end

    // Frame interrupted by reset while payload is streaming.
    drive_pin(1'b1, 2'b01, 1'b0);
    @(negedge clk);
    drive_pin(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_pin(1'b1, 2'b10, 1'b0);
    end
    @(negedge clk);
    check("mid_outclk_before", outclk, 1'b1);
    tb_drv = 1'b0;
    reset  = 1'b1;
    #1;
    check("mid_outclk", outclk, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_rstn", rstn, 1'b0);
    check("mid_out", out, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      check("post_done", done, 1'b0);
      check("post_outclk", outclk, 1'b0);
    end
    check("post_rstn", rstn, 1'b1);
    check("post_crsdv_released", crsdv !== 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
